// File: rtl/rv_pkg.sv
// Shared RV32I execute-side definitions.
//
// Contents:
//   ALU_* constants : ALU operation codes driven on the 5-bit alu op port.
//                     Codes 1..10 produce a result on y; codes 11..13 are
//                     branch comparisons that only drive cmp_taken.
//   ex_in_t         : decoded-instruction bundle handed from ID to EX.
package rv_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_BEQ  = 5'd11;
    localparam logic [4:0] ALU_BNE  = 5'd12;
    localparam logic [4:0] ALU_BLT  = 5'd13;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        a_pc;
        logic        b_imm;
        logic        branch;
        logic        br_use_y;
        logic        br_inv;
        logic        jal;
        logic        jalr;
        logic        wb_en;
    } ex_in_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU.
//
// Ports:
//   op_i        : operation code (rv_pkg ALU_* constants)
//   a_i, b_i    : operands
//   y_o         : arithmetic/logic result (0 for comparison-only codes)
//   cmp_taken_o : branch comparison outcome for BEQ/BNE/BLT codes, else 0
module alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o,
    output logic            cmp_taken_o
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [4:0]             shamt;

    assign a_s   = a_i;
    assign b_s   = b_i;
    assign shamt = b_i[4:0];

    always_comb begin
        y_o         = '0;
        cmp_taken_o = 1'b0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = a_s >>> shamt;
            ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_BEQ:  cmp_taken_o = (a_i == b_i);
            ALU_BNE:  cmp_taken_o = (a_i != b_i);
            ALU_BLT:  cmp_taken_o = (a_s < b_s);
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage with EX/MEM pipeline register.
//
// Accepts one decoded instruction per in_valid/in_ready handshake, resolves
// rs1/rs2 against the MEM and WB forwarding sources, evaluates the ALU and
// control-transfer targets in the accept cycle, and registers the outcome
// into the EX/MEM register (out_* ports, out_valid/out_ready handshake).
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_*                       : decoded instruction from ID + handshake
//   mem_fwd_*, wb_fwd_*        : forwarding sources (MEM has priority)
//   flush                      : squash EX/MEM contents and same-cycle accept
//   out_*                      : EX/MEM register contents + handshake
//   redirect_valid/redirect_pc : one-cycle fetch redirect for taken
//                                branches and jumps
module ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_alu_op,
    input  logic            in_a_pc,
    input  logic            in_b_imm,
    input  logic            in_branch,
    input  logic            in_br_use_y,
    input  logic            in_br_inv,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic            in_wb_en,

    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_val,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    // Operand resolution: MEM beats WB beats register file; x0 is always 0.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            m_en,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_val,
        input logic            w_en,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_val
    );
        logic [XLEN-1:0] r;
        if (idx == 5'd0) begin
            r = '0;
        end else if (m_en && (m_rd == idx)) begin
            r = m_val;
        end else if (w_en && (w_rd == idx)) begin
            r = w_val;
        end else begin
            r = rf_val;
        end
        return r;
    endfunction

    ex_in_t          ins;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic            alu_cmp;
    logic            br_taken;
    logic            ctrl_taken;
    logic            is_jump;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            accept;

    logic            valid_q,  valid_d;
    logic            redir_q,  redir_d;
    logic            wb_q,     wb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] rs2_q,    rs2_d;
    logic [XLEN-1:0] rpc_q,    rpc_d;
    logic [4:0]      rd_q,     rd_d;

    always_comb begin
        ins          = '0;
        ins.pc       = in_pc;
        ins.rs1_val  = in_rs1_val;
        ins.rs2_val  = in_rs2_val;
        ins.rs1      = in_rs1;
        ins.rs2      = in_rs2;
        ins.rd       = in_rd;
        ins.imm      = in_imm;
        ins.alu_op   = in_alu_op;
        ins.a_pc     = in_a_pc;
        ins.b_imm    = in_b_imm;
        ins.branch   = in_branch;
        ins.br_use_y = in_br_use_y;
        ins.br_inv   = in_br_inv;
        ins.jal      = in_jal;
        ins.jalr     = in_jalr;
        ins.wb_en    = in_wb_en;
    end

    // The register only frees up when it is empty or being drained; flush
    // deliberately does not gate this.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // ---- EX stage: forwarding, ALU, control-transfer resolution ----
    always_comb begin
        fwd_rs1 = fwd_operand(ins.rs1, ins.rs1_val, mem_fwd_en, mem_fwd_rd,
                              mem_fwd_val, wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        fwd_rs2 = fwd_operand(ins.rs2, ins.rs2_val, mem_fwd_en, mem_fwd_rd,
                              mem_fwd_val, wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        alu_a   = ins.a_pc  ? ins.pc  : fwd_rs1;
        alu_b   = ins.b_imm ? ins.imm : fwd_rs2;
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op_i        (ins.alu_op),
        .a_i         (alu_a),
        .b_i         (alu_b),
        .y_o         (alu_y),
        .cmp_taken_o (alu_cmp)
    );

    always_comb begin
        is_jump    = ins.jal || ins.jalr;
        // BLTU/BGEU reuse SLTU, so their outcome arrives on y[0].
        br_taken   = (ins.br_use_y ? alu_y[0] : alu_cmp) ^ ins.br_inv;
        ctrl_taken = is_jump || (ins.branch && br_taken);
        if (ins.jalr) begin
            target = (fwd_rs1 + ins.imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            target = ins.pc + ins.imm;
        end
        result = is_jump ? (ins.pc + {{(XLEN-3){1'b0}}, 3'd4}) : alu_y;
    end

    // ---- EX/MEM register next state ----
    always_comb begin
        valid_d  = valid_q;
        redir_d  = 1'b0;
        wb_d     = wb_q;
        result_d = result_q;
        rs2_d    = rs2_q;
        rpc_d    = rpc_q;
        rd_d     = rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            redir_d  = ctrl_taken;
            // Branches never write back, taken or not.
            wb_d     = ins.wb_en && (ins.rd != 5'd0) && !ins.branch;
            result_d = result;
            rs2_d    = fwd_rs2;
            rpc_d    = target;
            rd_d     = ins.rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ---- EX/MEM register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            redir_q  <= 1'b0;
            wb_q     <= 1'b0;
            result_q <= '0;
            rs2_q    <= '0;
            rpc_q    <= '0;
            rd_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            redir_q  <= redir_d;
            wb_q     <= wb_d;
            result_q <= result_d;
            rs2_q    <= rs2_d;
            rpc_q    <= rpc_d;
            rd_q     <= rd_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_rs2_val    = rs2_q;
    assign out_rd         = rd_q;
    assign out_wb_en      = wb_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd, in_alu_op;
    logic        in_a_pc, in_b_imm, in_branch, in_br_use_y, in_br_inv;
    logic        in_jal, in_jalr, in_wb_en;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        flush;
    logic        out_valid, out_ready, out_wb_en;
    logic [31:0] out_result, out_rs2_val;
    logic [4:0]  out_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int vectors     = 0;
    int miscompares = 0;

    // Expected EX/MEM contents held by the reference model.
    logic        e_valid, e_redir, e_wb;
    logic [31:0] e_res, e_rs2, e_rpc;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_a_pc(in_a_pc), .in_b_imm(in_b_imm),
        .in_branch(in_branch), .in_br_use_y(in_br_use_y), .in_br_inv(in_br_inv),
        .in_jal(in_jal), .in_jalr(in_jalr), .in_wb_en(in_wb_en),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_val(wb_fwd_val),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (mem_fwd_en && mem_fwd_rd == idx) return mem_fwd_val;
        if (wb_fwd_en && wb_fwd_rd == idx) return wb_fwd_val;
        return rf;
    endfunction

    task automatic clr();
        in_valid = 0; in_pc = 0; in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_alu_op = 0;
        in_a_pc = 0; in_b_imm = 0; in_branch = 0; in_br_use_y = 0; in_br_inv = 0;
        in_jal = 0; in_jalr = 0; in_wb_en = 0;
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_val = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_val = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic compare_all();
        check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_redir});
        if (e_valid) begin
            check("out_result", out_result, e_res);
            check("out_rs2_val", out_rs2_val, e_rs2);
            check("out_rd", {27'd0, out_rd}, {27'd0, e_rd});
            check("out_wb_en", {31'd0, out_wb_en}, {31'd0, e_wb});
        end
        if (e_redir) check("redirect_pc", redirect_pc, e_rpc);
    endtask

    // One clock with the currently driven inputs; model predicts the
    // register contents after the edge, which are then compared.
    task automatic step();
        logic        acc, cmp, tk, jump;
        logic [31:0] r1, r2, a, b, y, tgt;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!e_valid || out_ready)});
        acc  = in_valid && (!e_valid || out_ready);
        r1   = fwd(in_rs1, in_rs1_val);
        r2   = fwd(in_rs2, in_rs2_val);
        a    = in_a_pc ? in_pc : r1;
        b    = in_b_imm ? in_imm : r2;
        y    = 0;
        cmp  = 0;
        case (in_alu_op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
            ALU_BEQ:  cmp = (a == b);
            ALU_BNE:  cmp = (a != b);
            ALU_BLT:  cmp = ($signed(a) < $signed(b));
            default:  y = 0;
        endcase
        jump = in_jal || in_jalr;
        tk   = jump || (in_branch && ((in_br_use_y ? y[0] : cmp) ^ in_br_inv));
        tgt  = in_jalr ? ((r1 + in_imm) & 32'hFFFF_FFFE) : (in_pc + in_imm);
        if (!rst_n) begin
            e_valid = 0; e_redir = 0; e_wb = 0; e_res = 0; e_rs2 = 0; e_rpc = 0; e_rd = 0;
        end else if (flush) begin
            e_valid = 0; e_redir = 0;
        end else if (acc) begin
            e_valid = 1; e_redir = tk;
            e_res   = jump ? in_pc + 32'd4 : y;
            e_rs2   = r2; e_rd = in_rd; e_rpc = tgt;
            e_wb    = in_wb_en && (in_rd != 0) && !in_branch;
        end else begin
            e_redir = 0;
            if (out_ready) e_valid = 0;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_redir"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_wb"}, {31'd0, out_wb_en}, 32'd0);
        check({tag, "_res"}, out_result, 32'd0);
        check({tag, "_rs2"}, out_rs2_val, 32'd0);
        check({tag, "_rpc"}, redirect_pc, 32'd0);
        check({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
    endtask

    task automatic rand_instr();
        int kind, sub;
        clr();
        in_valid   = ($urandom % 4) != 0;
        out_ready  = ($urandom % 3) != 0;
        flush      = ($urandom % 16) == 0;
        in_pc      = $urandom & 32'hFFFF_FFFC;
        in_rs1     = 5'($urandom % 8);
        in_rs2     = 5'($urandom % 8);
        in_rd      = 5'($urandom % 8);
        in_rs1_val = $urandom;
        in_rs2_val = ($urandom % 2) ? in_rs1_val : $urandom;
        in_imm     = 32'($urandom_range(0, 4095)) - 32'd2048;
        mem_fwd_en = $urandom % 2; mem_fwd_rd = 5'($urandom % 8); mem_fwd_val = $urandom;
        wb_fwd_en  = $urandom % 2; wb_fwd_rd  = 5'($urandom % 8); wb_fwd_val  = $urandom;
        kind = $urandom % 6;
        case (kind)
            0: begin in_alu_op = 5'($urandom_range(1, 10)); in_wb_en = 1; end
            1: begin in_alu_op = 5'($urandom_range(1, 10)); in_b_imm = 1; in_wb_en = 1; end
            2: begin in_alu_op = ALU_ADD; in_a_pc = 1; in_b_imm = 1; in_wb_en = 1; end
            3: begin
                in_branch = 1; in_br_inv = $urandom % 2; in_wb_en = $urandom % 2;
                sub = $urandom % 3;
                if (sub == 0) in_alu_op = 5'($urandom_range(11, 13));
                else begin in_br_use_y = 1; in_alu_op = (sub == 1) ? ALU_SLT : ALU_SLTU; end
            end
            4: begin in_jal = 1; in_wb_en = 1; end
            default: begin in_jalr = 1; in_wb_en = 1; end
        endcase
    endtask

    initial begin
        clr();
        e_valid = 0; e_redir = 0; e_wb = 0; e_res = 0; e_rs2 = 0; e_rpc = 0; e_rd = 0;

        // Reset for two edges with a transfer offered; reset must win.
        rst_n = 0;
        in_valid = 1; in_jal = 1; in_pc = 32'h40; in_imm = 32'h8; in_rd = 5'd1; in_wb_en = 1;
        step(); check_all_zero("rst1");
        step(); check_all_zero("rst2");
        clr();
        rst_n = 1;
        #1;
        check_all_zero("rst_rel");
        step();

        // ADDI x7 = x5(10) + (-3)
        clr(); in_valid = 1; in_rs1 = 5; in_rs1_val = 10; in_imm = 32'hFFFF_FFFD;
        in_alu_op = ALU_ADD; in_b_imm = 1; in_rd = 7; in_wb_en = 1;
        step();
        check("addi_res", out_result, 32'd7);
        check("addi_wb", {31'd0, out_wb_en}, 32'd1);

        // MEM forwarding beats WB
        clr(); in_valid = 1; in_rs1 = 3; in_rs1_val = 32'h99; in_rs2 = 0; in_rs2_val = 32'h55;
        in_alu_op = ALU_ADD; in_rd = 9; in_wb_en = 1;
        mem_fwd_en = 1; mem_fwd_rd = 3; mem_fwd_val = 32'h11;
        wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_val = 32'h22;
        step();
        check("fwd_mem", out_result, 32'h11);

        // WB only
        mem_fwd_en = 0;
        step();
        check("fwd_wb", out_result, 32'h22);

        // x0 ignores forwarding
        in_rs1 = 0; mem_fwd_en = 1; mem_fwd_rd = 0; wb_fwd_rd = 0;
        step();
        check("fwd_x0", out_result, 32'h0);

        // BEQ taken
        clr(); in_valid = 1; in_pc = 32'h100; in_imm = 32'h20; in_branch = 1;
        in_alu_op = ALU_BEQ; in_rs1 = 1; in_rs1_val = 5; in_rs2 = 2; in_rs2_val = 5;
        step();
        check("beq_redir", {31'd0, redirect_valid}, 32'd1);
        check("beq_rpc", redirect_pc, 32'h120);
        check("beq_wb", {31'd0, out_wb_en}, 32'd0);
        in_valid = 0;
        step();
        check("beq_redir_once", {31'd0, redirect_valid}, 32'd0);

        // BGEU via SLTU inverted, 1 < 0xFFFFFFFF -> not taken
        clr(); in_valid = 1; in_pc = 32'h200; in_imm = 32'h40; in_branch = 1;
        in_br_use_y = 1; in_br_inv = 1; in_alu_op = ALU_SLTU;
        in_rs1 = 1; in_rs1_val = 1; in_rs2 = 2; in_rs2_val = 32'hFFFF_FFFF;
        in_rd = 4; in_wb_en = 1;
        step();
        check("bgeu_redir", {31'd0, redirect_valid}, 32'd0);
        check("bgeu_wb", {31'd0, out_wb_en}, 32'd0);

        // JALR clears bit 0 of target
        clr(); in_valid = 1; in_pc = 32'h400; in_jalr = 1; in_rs1 = 4; in_rs1_val = 32'h203;
        in_imm = 0; in_rd = 1; in_wb_en = 1;
        step();
        check("jalr_rpc", redirect_pc, 32'h202);
        check("jalr_res", out_result, 32'h404);

        // JAL wrap-around of target and link
        clr(); in_valid = 1; in_pc = 32'hFFFF_FFFC; in_jal = 1; in_imm = 32'h14; in_rd = 2; in_wb_en = 1;
        step();
        check("wrap_rpc", redirect_pc, 32'h10);
        check("wrap_res", out_result, 32'h0);

        // Backpressure after JAL
        clr(); in_valid = 1; in_pc = 32'h500; in_jal = 1; in_imm = 32'h40; in_rd = 1; in_wb_en = 1;
        step();
        check("bp_redir0", {31'd0, redirect_valid}, 32'd1);
        clr(); out_ready = 0; in_valid = 1; in_rs1 = 6; in_rs1_val = 32'h1000; in_imm = 32'h5;
        in_alu_op = ALU_ADD; in_b_imm = 1; in_rd = 3; in_wb_en = 1;
        for (int i = 0; i < 3; i++) begin
            mem_fwd_en = 1; mem_fwd_rd = 6; mem_fwd_val = 32'hAA00 + 32'(i);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_res", out_result, 32'h504);
            check("bp_rpc", redirect_pc, 32'h540);
            check("bp_rd", {27'd0, out_rd}, 32'd1);
            check("bp_redir", {31'd0, redirect_valid}, 32'd0);
        end
        // Drain and accept together: pending ADDI loads with no bubble,
        // using the forwarding value present in this accept cycle.
        out_ready = 1; mem_fwd_en = 0;
        step();
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_res", out_result, 32'h1005);

        // Flush with accept
        clr(); in_valid = 1; in_pc = 32'h600; in_jal = 1; in_imm = 32'h10; in_rd = 1; in_wb_en = 1;
        flush = 1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_redir", {31'd0, redirect_valid}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rand_instr();
            step();
        end

        clr();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
